execute_stage_md: RTL
=====================

# execute_stage_md

Parametrised execute stage for the in-order RV32 pipeline, sitting between the ID/EX and EX/MEM boundaries. It selects ALU operands, performs single-cycle ALU operations, and optionally runs an iterative multiply/divide unit. Its single-entry EX/MEM output register carries valid/ready handshakes on both sides, so downstream stalls, multi-cycle operations and flushes all propagate correctly.

## Interface
- WIDTH, 32: datapath width
- ADDR_LEN, 32: PC width
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid / in_ready  input / output  1  ID/EX handshake; transfer when both high on a clock edge
- opsel1, opsel2  input  2  operand selects: 2'b00 picks RS1/RS2, 2'b01 picks PC/IMM, others give 0
- alu_func  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_OP2, 15 M-class, others give 0
- funct7, funct3  input  7, 3  M-class qualifier (funct7==7'b0000001) and M op select
- rs1_data_i, rs2_data_i, imm  input  WIDTH  operands
- pc_i  input  ADDR_LEN; rd_addr_i 5; rf_w_en_i 1; wbsel_i 2; mem_w_en_i 1  sideband
- flush  input  1  kills in-flight and held work
- out_valid / out_ready  output / input  1  EX/MEM handshake
- pc_o, alu_out, rd_addr_o, rf_w_en_o, wbsel_o, mem_w_en_o, rs2_data_o  output  registered copies and result
- busy  output  1  multiply/divide in progress

## Operation
- An M op requires alu_func==15 and funct7==7'b0000001. Every other operation is single-cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Single-cycle accept: the result and sideband load into the output register and out_valid=1.
- M accept: operands and sideband are captured, the state moves to BUSY, and the counter loads WIDTH.
- BUSY: one bit is processed per cycle (shift-add multiply, restoring divide) and the counter decrements.
- When the counter reaches 0: if the output slot is free (!out_valid || out_ready), the result is written, out_valid=1 and the state returns to IDLE. Otherwise the state moves to DONE and waits.
- States: IDLE→BUSY (M accept); BUSY→DONE or IDLE; DONE→IDLE when the slot frees.
- funct3 M ops: 0 MUL (low word), 1 MULH (s×s), 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (min / −1): quotient = min, remainder = 0.
- Shifts use op2[4:0]. All arithmetic wraps modulo 2^WIDTH.
- rf_w_en_o and mem_w_en_o read 0 whenever out_valid=0.
- Outputs hold stable while out_valid && !out_ready.
- flush (synchronous): clears out_valid, aborts BUSY or DONE to IDLE, and blocks acceptance that cycle. flush has priority over every other event.

## Timing
- Reset: all outputs and registers are 0, busy=0, state IDLE. in_ready reads 1 once reset_n is released.
- Single-cycle latency is 1: accept at edge N, out_valid at N+1.
- Back-to-back throughput is one per cycle when out_ready is held high.
- M latency is WIDTH+1 edges from accept to out_valid (33 at default). busy is high for WIDTH cycles.
- Simultaneous drain and accept: the same edge that pops the slot may load a new result.
- reset_n asserted mid-operation aborts immediately and asynchronously.

## Configuration
- EXEC_MULDIV_EN defined: the M unit, BUSY/DONE states and busy output are built.
- EXEC_MULDIV_EN undefined: M ops complete as single-cycle with alu_out=0 and rf_w_en_o forced to 0. busy is tied to 0 and the state stays IDLE.

## Test plan
- After reset, with opsel 00/00 and ADD: rs1=5, rs2=7 → alu_out=12 and out_valid=1 one cycle after accept.
- PC+imm path (opsel 01/01): pc=0x100, imm=0x20, ADD → alu_out=0x120. SRA of 0x80000000 by 4 → 0xF8000000.
- Hold out_ready=0 for 3 cycles with 2 ops queued → in_ready=0 and outputs stable. On release, one result drains per cycle in order.
- MUL 0xFFFFFFFF×2 → 0xFFFFFFFE. MULHU of the same operands → 0x00000001. DIV 7/0 → 0xFFFFFFFF. REM 0x80000000/−1 → 0. Each completes 33 cycles after accept.
- flush asserted at cycle 10 of a DIV → busy=0 and out_valid=0 next cycle, and no result ever appears. An ADD accepted afterwards completes normally.
- With EXEC_MULDIV_EN undefined: MUL 3×4 → out_valid after 1 cycle, with alu_out=0 and rf_w_en_o=0.

Source files
------------

// File: rtl/execute_stage_md.sv
// Execute stage: operand select, single-cycle ALU and a single-entry EX/MEM output slot.
// Define EXEC_MULDIV_EN to build the iterative multiply/divide unit (BUSY/DONE states, busy output).
module execute_stage_md #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          opsel1,
    input  logic [1:0]          opsel2,
    input  logic [3:0]          alu_func,
    input  logic [6:0]          funct7,
    input  logic [2:0]          funct3,
    input  logic [WIDTH-1:0]    rs1_data_i,
    input  logic [WIDTH-1:0]    rs2_data_i,
    input  logic [WIDTH-1:0]    imm,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rf_w_en_i,
    input  logic [1:0]          wbsel_i,
    input  logic                mem_w_en_i,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [WIDTH-1:0]    alu_out,
    output logic [4:0]          rd_addr_o,
    output logic                rf_w_en_o,
    output logic [1:0]          wbsel_o,
    output logic                mem_w_en_o,
    output logic [WIDTH-1:0]    rs2_data_o,
    output logic                busy
);
    logic [WIDTH-1:0]    w_op1, w_op2, w_alu_res;
    logic [4:0]          w_shamt;
    logic                w_is_m, w_slot_free, w_idle, w_accept, w_single_acc, w_m_done;
    logic                r_out_valid, r_rf_w_en, r_mem_w_en;
    logic [ADDR_LEN-1:0] r_pc;
    logic [WIDTH-1:0]    r_alu, r_rs2;
    logic [4:0]          r_rd;
    logic [1:0]          r_wbsel;

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (opsel1)
            2'b00:   w_op1 = rs1_data_i;
            2'b01:   w_op1 = WIDTH'(pc_i);
            default: w_op1 = '0;
        endcase
        case (opsel2)
            2'b00:   w_op2 = rs2_data_i;
            2'b01:   w_op2 = imm;
            default: w_op2 = '0;
        endcase
    end

    assign w_shamt = w_op2[4:0];

    always_comb begin
        w_alu_res = '0;
        case (alu_func)
            4'd0:    w_alu_res = w_op1 + w_op2;
            4'd1:    w_alu_res = w_op1 - w_op2;
            4'd2:    w_alu_res = w_op1 << w_shamt;
            4'd3:    w_alu_res = {{(WIDTH-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            4'd4:    w_alu_res = {{(WIDTH-1){1'b0}}, w_op1 < w_op2};
            4'd5:    w_alu_res = w_op1 ^ w_op2;
            4'd6:    w_alu_res = w_op1 >> w_shamt;
            4'd7:    w_alu_res = $unsigned($signed(w_op1) >>> w_shamt);
            4'd8:    w_alu_res = w_op1 | w_op2;
            4'd9:    w_alu_res = w_op1 & w_op2;
            4'd10:   w_alu_res = w_op2;
            default: w_alu_res = '0;
        endcase
    end

    assign w_is_m      = (alu_func == 4'd15) && (funct7 == 7'b0000001);
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = w_idle && w_slot_free && !flush;
    assign w_accept    = in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_p, w_p_step, w_prod;
    logic [WIDTH-1:0]      r_b, w_abs_a, w_abs_b, w_q, w_r, w_m_res;
    logic [WIDTH:0]        w_sum, w_shift, w_diff;
    logic [2:0]            r_op;
    logic                  r_neg_res, r_neg_rem, w_sa, w_sb;
    logic [ADDR_LEN-1:0]   r_m_pc;
    logic [WIDTH-1:0]      r_m_rs2;
    logic [4:0]            r_m_rd;
    logic [1:0]            r_m_wbsel;
    logic                  r_m_rf_w_en, r_m_mem_w_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_m) w_state_next = S_BUSY;
                S_BUSY:  if (r_cnt == '0) w_state_next = w_slot_free ? S_IDLE : S_DONE;
                S_DONE:  if (w_slot_free) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_idle       = (r_state == S_IDLE);
    assign busy         = (r_state == S_BUSY) && (r_cnt != '0);
    assign w_single_acc = w_accept && !w_is_m;
    assign w_m_done     = !flush && w_slot_free &&
                          (((r_state == S_BUSY) && (r_cnt == '0)) || (r_state == S_DONE));

    // Both units run on magnitudes; signs are reapplied when the result is read out.
    assign w_sa    = (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd6) && w_op1[WIDTH-1];
    assign w_sb    = (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6) && w_op2[WIDTH-1];
    assign w_abs_a = w_sa ? -w_op1 : w_op1;
    assign w_abs_b = w_sb ? -w_op2 : w_op2;

    assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_p_step = r_op[2] ? {(w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                                 r_p[WIDTH-2:0], ~w_diff[WIDTH]}
                              : {w_sum, r_p[WIDTH-1:1]};

    assign w_prod = r_neg_res ? -r_p : r_p;
    assign w_q    = r_p[WIDTH-1:0];
    assign w_r    = r_p[2*WIDTH-1:WIDTH];

    always_comb begin
        w_m_res = '0;
        case (r_op)
            3'd0:       w_m_res = w_prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: w_m_res = w_prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5: w_m_res = r_neg_res ? -w_q : w_q;
            default:    w_m_res = r_neg_rem ? -w_r : w_r;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p <= '0;  r_b <= '0;  r_cnt <= '0;  r_op <= '0;
            r_neg_res <= 1'b0;  r_neg_rem <= 1'b0;
            r_m_pc <= '0;  r_m_rs2 <= '0;  r_m_rd <= '0;  r_m_wbsel <= '0;
            r_m_rf_w_en <= 1'b0;  r_m_mem_w_en <= 1'b0;
        end else if (w_accept && w_is_m) begin
            r_p          <= {{WIDTH{1'b0}}, w_abs_a};
            r_b          <= w_abs_b;
            r_cnt        <= CW'(WIDTH);
            r_op         <= funct3;
            // A zero divisor yields an all-ones quotient, which must not be negated.
            r_neg_res    <= (w_sa ^ w_sb) && !(funct3[2] && (w_op2 == '0));
            r_neg_rem    <= w_sa;
            r_m_pc       <= pc_i;
            r_m_rs2      <= rs2_data_i;
            r_m_rd       <= rd_addr_i;
            r_m_wbsel    <= wbsel_i;
            r_m_rf_w_en  <= rf_w_en_i;
            r_m_mem_w_en <= mem_w_en_i;
        end else if (!flush && (r_state == S_BUSY) && (r_cnt != '0)) begin
            r_p   <= w_p_step;
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_idle       = 1'b1;
    assign busy         = 1'b0;
    assign w_single_acc = w_accept;
    assign w_m_done     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;  r_pc <= '0;  r_alu <= '0;  r_rs2 <= '0;
            r_rd <= '0;  r_wbsel <= '0;  r_rf_w_en <= 1'b0;  r_mem_w_en <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_single_acc) begin
            r_out_valid <= 1'b1;
            r_pc        <= pc_i;
            r_alu       <= w_alu_res;
            r_rs2       <= rs2_data_i;
            r_rd        <= rd_addr_i;
            r_wbsel     <= wbsel_i;
            r_rf_w_en   <= rf_w_en_i && !w_is_m;
            r_mem_w_en  <= mem_w_en_i;
`ifdef EXEC_MULDIV_EN
        end else if (w_m_done) begin
            r_out_valid <= 1'b1;
            r_pc        <= r_m_pc;
            r_alu       <= w_m_res;
            r_rs2       <= r_m_rs2;
            r_rd        <= r_m_rd;
            r_wbsel     <= r_m_wbsel;
            r_rf_w_en   <= r_m_rf_w_en;
            r_mem_w_en  <= r_m_mem_w_en;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign pc_o       = r_pc;
    assign alu_out    = r_alu;
    assign rs2_data_o = r_rs2;
    assign rd_addr_o  = r_rd;
    assign wbsel_o    = r_wbsel;
    assign rf_w_en_o  = r_rf_w_en && r_out_valid;
    assign mem_w_en_o = r_mem_w_en && r_out_valid;
endmodule
